// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the scrubbing multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } scrub_state_e;

endpackage

// File: rtl/regfile_scrub_fsm.sv
// Scrub sequencer: walks a pointer over every register once per clear request.
module regfile_scrub_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_req_i,
  output logic                     scrub_en_o,
  output logic [$clog2(DEPTH)-1:0] scrub_addr_o,
  output logic                     busy_o
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  scrub_state_e      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;

  // State, pointer and busy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: clear_req is only honoured in IDLE; SCRUB exits after the last register.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clear_req_i) begin
          state_d = SCRUB;
          ptr_d   = '0;
        end else begin
          state_d = IDLE;
          ptr_d   = ptr_q;
        end
      end
      SCRUB: begin
        if (ptr_q == LAST_ADDR) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          state_d = SCRUB;
          ptr_d   = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Outputs: busy is registered from the next state so it tracks SCRUB exactly.
  always_comb begin
    busy_d       = (state_d == SCRUB);
    scrub_en_o   = (state_q == SCRUB);
    scrub_addr_o = ptr_q;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp_scrub.sv
// Two-read / two-write register file with optional forwarding, optional zero
// register and a sequential clear engine.
module regfile_mp_scrub
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(DEPTH)-1:0] read_addr1,
  input  logic [$clog2(DEPTH)-1:0] read_addr2,
  output logic [DATA_W-1:0]        read_data1,
  output logic [DATA_W-1:0]        read_data2,
  input  logic [$clog2(DEPTH)-1:0] write_addr,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     write_enable,
  input  logic [$clog2(DEPTH)-1:0] write_addr2,
  input  logic [DATA_W-1:0]        write_data2,
  input  logic                     write_enable2,
  input  logic                     clear_req,
  output logic                     busy
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              scrub_en;
  logic [ADDR_W-1:0] scrub_addr;
  logic              wr_ok_a;
  logic              wr_ok_b;

  regfile_scrub_fsm #(
    .DEPTH(DEPTH)
  ) u_scrub_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_req_i (clear_req),
    .scrub_en_o  (scrub_en),
    .scrub_addr_o(scrub_addr),
    .busy_o      (busy)
  );

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  assign wr_ok_a = write_enable  && !scrub_en && !is_zero_reg(write_addr);
  assign wr_ok_b = write_enable2 && !scrub_en && !is_zero_reg(write_addr2);

  // Forwarding mirrors commit rules, so a read sees exactly what the edge will store.
  function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] ra);
    logic fwd_a;
    logic fwd_b;
    fwd_a = (BYPASS != 0) && wr_ok_a && (write_addr  == ra);
    fwd_b = (BYPASS != 0) && wr_ok_b && (write_addr2 == ra);
    return is_zero_reg(ra) ? '0 :
           fwd_a           ? write_data :
           fwd_b           ? write_data2 :
                             regs_q[ra];
  endfunction

  assign read_data1 = read_mux(read_addr1);
  assign read_data2 = read_mux(read_addr2);

  // Next array contents: scrub clear, else port A over port B, else hold.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = (scrub_en && (scrub_addr == ADDR_W'(i)))  ? '0 :
                  (wr_ok_a  && (write_addr  == ADDR_W'(i))) ? write_data :
                  (wr_ok_b  && (write_addr2 == ADDR_W'(i))) ? write_data2 :
                                                              regs_q[i];
    end
  end

  // Register array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_scrub.sv
// Randomised bench: three configurations share stimulus and are compared
// every cycle against a behavioural array model.
module tb_regfile_mp_scrub;

  localparam int NI = 3;
  localparam int ND = 4;
  localparam bit BYP [NI] = '{1'b1, 1'b0, 1'b1};
  localparam bit ZR  [NI] = '{1'b0, 1'b0, 1'b1};

  logic        clk;
  logic        rst_n;
  logic [1:0]  ra1, ra2, wa, wa2;
  logic [63:0] wd, wd2;
  logic        we, we2, clr;
  logic [63:0] rd1 [NI];
  logic [63:0] rd2 [NI];
  logic        bsy [NI];

  int checks;
  int failures;
  bit chk_en;

  logic [63:0] mem [NI][ND];
  int          scrub_left;

  regfile_mp_scrub #(.BYPASS(1), .ZERO_REG(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .read_addr1(ra1), .read_addr2(ra2),
    .read_data1(rd1[0]), .read_data2(rd2[0]), .write_addr(wa), .write_data(wd),
    .write_enable(we), .write_addr2(wa2), .write_data2(wd2), .write_enable2(we2),
    .clear_req(clr), .busy(bsy[0]));

  regfile_mp_scrub #(.BYPASS(0), .ZERO_REG(0)) u_dut_nobyp (
    .clk(clk), .rst_n(rst_n), .read_addr1(ra1), .read_addr2(ra2),
    .read_data1(rd1[1]), .read_data2(rd2[1]), .write_addr(wa), .write_data(wd),
    .write_enable(we), .write_addr2(wa2), .write_data2(wd2), .write_enable2(we2),
    .clear_req(clr), .busy(bsy[1]));

  regfile_mp_scrub #(.BYPASS(1), .ZERO_REG(1)) u_dut_zero (
    .clk(clk), .rst_n(rst_n), .read_addr1(ra1), .read_addr2(ra2),
    .read_data1(rd1[2]), .read_data2(rd2[2]), .write_addr(wa), .write_data(wd),
    .write_enable(we), .write_addr2(wa2), .write_data2(wd2), .write_enable2(we2),
    .clear_req(clr), .busy(bsy[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d actual=%h required=%h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  // Model: scrub clears register (ND - scrub_left) on each edge; otherwise B then A writes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++)
        for (int a = 0; a < ND; a++) mem[k][a] <= 64'h0;
      scrub_left <= 0;
    end else if (scrub_left > 0) begin
      for (int k = 0; k < NI; k++) mem[k][ND - scrub_left] <= 64'h0;
      scrub_left <= scrub_left - 1;
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (we2 && !(ZR[k] && wa2 == 2'd0)) mem[k][wa2] <= wd2;
        if (we  && !(ZR[k] && wa  == 2'd0)) mem[k][wa]  <= wd;
      end
      if (clr) scrub_left <= ND;
    end
  end

  function automatic logic [63:0] exp_rd(input int k, input logic [1:0] ra);
    if (ZR[k] && ra == 2'd0) return 64'h0;
    if (BYP[k] && scrub_left == 0 && we  && wa  == ra) return wd;
    if (BYP[k] && scrub_left == 0 && we2 && wa2 == ra) return wd2;
    return mem[k][ra];
  endfunction

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        check("rd1", k, rd1[k], exp_rd(k, ra1));
        check("rd2", k, rd2[k], exp_rd(k, ra2));
        check("busy", k, {63'd0, bsy[k]}, {63'd0, scrub_left > 0});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; we2 = 1'b0; clr = 1'b0;
    wa = 2'd0; wa2 = 2'd0; wd = 64'h0; wd2 = 64'h0;
  endtask

  initial begin
    int bc;
    checks = 0; failures = 0; chk_en = 1'b0;
    rst_n = 1'b0;
    ra1 = 2'd0; ra2 = 2'd0;
    idle_inputs();
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset state on every address
    for (int a = 0; a < ND; a++) begin
      ra1 = 2'(a); ra2 = 2'(3 - a);
      #1;
      for (int k = 0; k < NI; k++) begin
        check("reset_rd1", k, rd1[k], 64'h0);
        check("reset_rd2", k, rd2[k], 64'h0);
      end
    end

    // Asynchronous reset between edges
    tick();
    we = 1'b1; wa = 2'd2; wd = 64'h1234;
    tick();
    idle_inputs(); ra1 = 2'd2;
    #2 check("pre_async", 1, rd1[1], 64'h1234);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) check("async_rst", k, rd1[k], 64'h0);
    #1 rst_n = 1'b1;

    // Same-cycle forwarding versus registered visibility
    tick();
    we = 1'b1; wa = 2'd2; wd = 64'hDEAD_BEEF_0000_0001; ra1 = 2'd2;
    #2;
    check("bypass_now", 0, rd1[0], 64'hDEAD_BEEF_0000_0001);
    check("nobyp_old", 1, rd1[1], 64'h0);
    tick();
    idle_inputs();
    #2 check("nobyp_new", 1, rd1[1], 64'hDEAD_BEEF_0000_0001);

    // Port A wins a same-address collision
    tick();
    we = 1'b1; wa = 2'd1; wd = 64'h11; we2 = 1'b1; wa2 = 2'd1; wd2 = 64'h22; ra1 = 2'd1;
    #2 check("prio_bypass", 0, rd1[0], 64'h11);
    tick();
    idle_inputs();
    #2 check("prio_store", 1, rd1[1], 64'h11);

    // Independent commits on distinct addresses
    tick();
    we = 1'b1; wa = 2'd0; wd = 64'h33; we2 = 1'b1; wa2 = 2'd3; wd2 = 64'h44;
    tick();
    idle_inputs(); ra1 = 2'd0; ra2 = 2'd3;
    #2;
    check("dual_a", 1, rd1[1], 64'h33);
    check("dual_b", 1, rd2[1], 64'h44);
    check("zero_a", 2, rd1[2], 64'h0);
    check("zero_b", 2, rd2[2], 64'h44);

    // Zero register under bypass
    tick();
    we = 1'b1; wa = 2'd0; wd = 64'hFFFF; ra1 = 2'd0;
    #2;
    check("zero_byp", 2, rd1[2], 64'h0);
    check("nonzero_byp", 0, rd1[0], 64'hFFFF);

    // Fill 1..4 then scrub while writes are attempted
    for (int a = 0; a < ND; a++) begin
      tick();
      we = 1'b1; wa = 2'(a); wd = 64'(a + 1);
    end
    tick();
    idle_inputs(); clr = 1'b1;
    tick();
    clr = 1'b0; we = 1'b1; wa = 2'd3; wd = 64'hBAD; ra1 = 2'd0; ra2 = 2'd3;
    bc = 0;
    for (int c = 0; c < 20 && bsy[0]; c++) begin
      #2;
      check("scrub_r0", 0, rd1[0], (c == 0) ? 64'd1 : 64'd0);
      check("scrub_r3", 0, rd2[0], 64'd4);
      bc++;
      tick();
    end
    check("busy_len", 0, 64'(bc), 64'd4);
    #2 check("post_scrub_byp", 0, rd2[0], 64'hBAD);
    tick();
    idle_inputs();
    #2 check("post_scrub_wr", 1, rd2[1], 64'hBAD);

    // Reset during scrub
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check("midscrub_busy", k, {63'd0, bsy[k]}, 64'd0);
      check("midscrub_rd2", k, rd2[k], 64'h0);
    end
    #1 rst_n = 1'b1;
    tick();
    we = 1'b1; wa = 2'd1; wd = 64'h55;
    tick();
    idle_inputs(); ra1 = 2'd1;
    #2 check("after_rst_wr", 1, rd1[1], 64'h55);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      tick();
      rst_n = 1'b1;
      ra1 = 2'($urandom_range(3)); ra2 = 2'($urandom_range(3));
      wa  = 2'($urandom_range(3)); wa2 = 2'($urandom_range(3));
      wd  = {$urandom, $urandom};  wd2 = {$urandom, $urandom};
      we  = ($urandom_range(3) != 0);
      we2 = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) wa2 = wa;
      clr = ($urandom_range(15) == 0);
      if ($urandom_range(99) == 0) begin
        #1 rst_n = 1'b0;
      end
    end
    tick();
    rst_n = 1'b1;
    idle_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp_scrub.md
Name: regfile_mp_scrub

Overview:
- Parametrised multi-port register file: generalised width and depth, two asynchronous read ports, two prioritised write ports.
- Adds optional write-to-read forwarding, an optional hardwired zero register, and a sequential scrub engine that clears the whole array on request.
- Serves as the datapath operand store for the pipeline.

Parameters:
- DATA_W, 64, width of each register in bits.
- DEPTH, 4, number of registers; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), address width; derived localparam, not overridable.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports; 0 = reads show array contents only.
- ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- read_addr1  in  ADDR_W  read port 1 address.
- read_addr2  in  ADDR_W  read port 2 address.
- read_data1  out  DATA_W  read port 1 data, combinational.
- read_data2  out  DATA_W  read port 2 data, combinational.
- write_addr  in  ADDR_W  write port A address (high priority).
- write_data  in  DATA_W  write port A data.
- write_enable  in  1  write port A enable.
- write_addr2  in  ADDR_W  write port B address (low priority).
- write_data2  in  DATA_W  write port B data.
- write_enable2  in  1  write port B enable.
- clear_req  in  1  single-cycle request to scrub every register to 0.
- busy  out  1  scrub in progress; writes are ignored while high.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0), immediate and independent of clk:
  - all DEPTH registers = 0.
  - busy = 0, FSM = IDLE, scrub pointer = 0.
  - read_data1/2 therefore read 0.
- Reads: combinational from the array, zero cycles latency.
  - BYPASS=1, busy=0: if an enabled write port matches the read address, that port's write_data appears on the read port in the same cycle.
  - If both write ports match the read address, port A data is forwarded.
  - BYPASS=0: reads return the pre-edge array value; new data is visible the cycle after the write.
- Writes: at posedge, only when busy=0.
  - Port A and port B commit independently when their addresses differ.
  - Same address, both enabled: port A's data is stored and port B's write is discarded.
- ZERO_REG=1: address 0 always reads 0, including under bypass; writes to address 0 are dropped.
- FSM states, IDLE and SCRUB:
  - IDLE -> SCRUB at the posedge where clear_req=1. Writes in that same cycle still commit. Pointer loads 0. busy rises after that edge.
  - In SCRUB, each posedge sets register[ptr] = 0 and increments ptr.
  - When ptr == DEPTH-1, that register is cleared and the FSM returns to IDLE. busy falls after that edge.
  - busy is high for exactly DEPTH cycles.
  - SCRUB ignores write_enable, write_enable2 and clear_req; there is no queuing or restart.
  - Reads during SCRUB return current array contents, partially cleared, with no bypass.
  - Pointer width is ADDR_W; wrap-around never occurs because the FSM exits at DEPTH-1.
- Reset asserted mid-scrub: immediate return to the reset state. The array is all zero, so there is no partial-state hazard.
- No X on outputs after reset for any address, including out-of-range addresses; DEPTH is a power of two.

Decomposition:
- Package regfile_pkg holds:
  - the FSM state enum (IDLE, SCRUB).
  - the default DATA_W and DEPTH constants.
- One sub-module, regfile_scrub_fsm, owns the state, pointer and busy.
  - Outputs: scrub_en, scrub_addr.
- Top level owns the array, write arbitration and the read/bypass muxes.

Test Plan:
- Reset, then read all addresses -> read_data1/2 = 0. Assert rst_n=0 between clock edges -> outputs drop to 0 without a clock edge.
- Write A addr 2 = 0xDEAD_BEEF_0000_0001 with read_addr1=2, BYPASS=1 -> read_data1 shows the value in the same cycle. With BYPASS=0 it shows the old value, then the new value after the edge.
- Both ports write addr 1: A = 0x11, B = 0x22 -> addr 1 reads 0x11. A addr 0 = 0x33 with B addr 3 = 0x44 in the same cycle -> both stored.
- ZERO_REG=1: write addr 0 = 0xFFFF -> read_data1 (addr 0) = 0, also in the bypass cycle.
- Fill regs with 1..4, pulse clear_req -> busy high for 4 cycles. Writes during busy are dropped. Register k reads 0 from cycle k+1 after the request. After busy falls, all read 0 and a new write succeeds.
- Pulse clear_req, drop rst_n at busy cycle 2, release -> busy=0, FSM IDLE, and a normal write works immediately.
